// File: rtl/vga_cmd_pkg.sv
// Shared definitions for the SPI drawing-command decoder and the VGA framebuffer path.
// Opcodes, decoder states and default framebuffer geometry live here.
package vga_cmd_pkg;

    localparam int DEF_H_RES  = 160;
    localparam int DEF_V_RES  = 120;
    localparam int DEF_PIX_W  = 8;
    localparam int DEF_ADDR_W = 15;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_POS   = 8'h01;
    localparam logic [7:0] OP_WRITE_PIX = 8'h02;
    localparam logic [7:0] OP_FILL      = 8'h03;
    localparam logic [7:0] OP_CLR_ERR   = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        GET_X,
        GET_Y,
        GET_COLOR,
        FILL_RUN
    } state_t;

    // True when an unsigned byte coordinate lies inside a dimension of size limit.
    function automatic logic in_bounds(input logic [7:0] v, input int limit);
        return int'(v) < limit;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Bundles the received-byte stream and the framebuffer write port of the command decoder.
// The SPI/testbench side uses the master modport; the decoder uses the slave modport.
interface spi_cmd_decoder_if
    import vga_cmd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              cs_n;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_wdata;
    logic              busy;
    logic              err;

    modport master (
        output rx_data, rx_valid, cs_n,
        input  fb_we, fb_addr, fb_wdata, busy, err
    );

    modport slave (
        input  rx_data, rx_valid, cs_n,
        output fb_we, fb_addr, fb_wdata, busy, err
    );

endinterface

// File: rtl/fb_cursor.sv
// Pixel cursor: x, y and the matching linear framebuffer address y*H_RES+x.
// Loads multiply once (registered); increments step the address without a multiplier.
module fb_cursor
    import vga_cmd_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [7:0]        load_x,
    input  logic [7:0]        load_y,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [7:0] X_LAST = 8'(H_RES - 1);
    localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic [ADDR_W-1:0] load_addr;

    assign load_addr = ADDR_W'(load_y) * ADDR_W'(H_RES) + ADDR_W'(load_x);

    // Clear beats load beats increment; the last pixel wraps back to the origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            addr <= '0;
        end else if (clr) begin
            x_q  <= '0;
            y_q  <= '0;
            addr <= '0;
        end else if (load) begin
            x_q  <= load_x;
            y_q  <= load_y;
            addr <= load_addr;
        end else if (inc) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                if (y_q == Y_LAST) begin
                    y_q  <= '0;
                    addr <= '0;
                end else begin
                    y_q  <= y_q + 8'd1;
                    addr <= addr + ADDR_W'(1);
                end
            end else begin
                x_q  <= x_q + 8'd1;
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns the SPI byte stream into drawing commands and drives the framebuffer write port.
// Holds the command FSM, the chip-select synchronizer and the sticky error flag.
module spi_cmd_decoder
    import vga_cmd_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_cmd_decoder_if.slave bus
);

    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(H_RES * V_RES - 1);

    state_t state, state_next;

    logic cs_meta, cs_sync, cs_sync_d, cs_rise;

    logic [7:0]        x_lat;
    logic              op_fill, op_fill_next;
    logic              we_q, we_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [PIX_W-1:0]  wdata_q, wdata_next;
    logic              busy_q, busy_next;
    logic              err_q, err_set, err_clr;
    logic              latch_x;
    logic              cur_clr, cur_load, cur_inc;
    logic [ADDR_W-1:0] cur_addr;

    assign cs_rise = cs_sync & ~cs_sync_d;

    fb_cursor #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cur_clr),
        .load   (cur_load),
        .load_x (x_lat),
        .load_y (bus.rx_data),
        .inc    (cur_inc),
        .addr   (cur_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_sync_d <= 1'b1;
            x_lat     <= '0;
            op_fill   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            cs_meta   <= bus.cs_n;
            cs_sync   <= cs_meta;
            cs_sync_d <= cs_sync;
            if (latch_x)
                x_lat <= bus.rx_data;
            op_fill   <= op_fill_next;
            we_q      <= we_next;
            addr_q    <= addr_next;
            wdata_q   <= wdata_next;
            busy_q    <= busy_next;
            // A new error outranks a simultaneous clear.
            if (err_set)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end

    always_comb begin
        state_next   = state;
        op_fill_next = op_fill;
        we_next      = 1'b0;
        addr_next    = addr_q;
        wdata_next   = wdata_q;
        busy_next    = busy_q;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        latch_x      = 1'b0;
        cur_clr      = 1'b0;
        cur_load     = 1'b0;
        cur_inc      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        OP_NOP:       ;
                        OP_SET_POS:   state_next = GET_X;
                        OP_WRITE_PIX: begin
                            state_next   = GET_COLOR;
                            op_fill_next = 1'b0;
                        end
                        OP_FILL: begin
                            state_next   = GET_COLOR;
                            op_fill_next = 1'b1;
                        end
                        OP_CLR_ERR:   err_clr = 1'b1;
                        default:      err_set = 1'b1;
                    endcase
                end
            end

            GET_X: begin
                if (bus.rx_valid) begin
                    latch_x    = 1'b1;
                    state_next = GET_Y;
                end
            end

            GET_Y: begin
                if (bus.rx_valid) begin
                    if (in_bounds(x_lat, H_RES) && in_bounds(bus.rx_data, V_RES))
                        cur_load = 1'b1;
                    else
                        err_set = 1'b1;
                    state_next = IDLE;
                end
            end

            GET_COLOR: begin
                if (bus.rx_valid) begin
                    state_next = IDLE;
                    if (!op_fill) begin
                        we_next    = 1'b1;
                        addr_next  = cur_addr;
                        wdata_next = PIX_W'(bus.rx_data);
                        cur_inc    = 1'b1;
                    end else if (!cs_rise) begin
                        // Address 0 is presented together with busy so both span the whole fill.
                        state_next = FILL_RUN;
                        we_next    = 1'b1;
                        addr_next  = '0;
                        wdata_next = PIX_W'(bus.rx_data);
                        busy_next  = 1'b1;
                    end
                end
            end

            FILL_RUN: begin
                if (bus.rx_valid)
                    err_set = 1'b1;
                if (addr_q == FB_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    cur_clr    = 1'b1;
                end else begin
                    we_next   = 1'b1;
                    addr_next = addr_q + ADDR_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase

        if (cs_rise && state != FILL_RUN)
            state_next = IDLE;
    end

    assign bus.fb_we    = we_q;
    assign bus.fb_addr  = addr_q;
    assign bus.fb_wdata = wdata_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: a command-level model queues expected framebuffer
// writes and error state, and a negedge monitor compares every cycle the DUT presents.
module tb_spi_cmd_decoder;
    import vga_cmd_pkg::*;

    localparam int H = 160;
    localparam int V = 120;
    localparam int N = H * V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_decoder_if #(.ADDR_W(15), .PIX_W(8)) bus ();

    spi_cmd_decoder #(
        .H_RES  (H),
        .V_RES  (V),
        .ADDR_W (15),
        .PIX_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks_total  = 0;
    int     checks_passed = 0;
    int     exp_q[$];
    int     last_write = 0;
    int     cyc = 0;
    longint busy_cycles = 0;

    // Reference model state: cursor, error flag, bytes of the command being collected.
    int mx = 0;
    int my = 0;
    bit merr = 1'b0;
    int pend[$];
    int fill_end = -1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks_total++;
        if (act == exp)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void modelByte(input int b, input int s);
        if (s <= fill_end) begin
            merr = 1'b1;
            return;
        end
        if (pend.size() == 0) begin
            case (b)
                0:       ;
                1, 2, 3: pend.push_back(b);
                4:       merr = 1'b0;
                default: merr = 1'b1;
            endcase
            return;
        end
        pend.push_back(b);
        if (pend[0] == 1 && pend.size() == 3) begin
            if (pend[1] < H && pend[2] < V) begin
                mx = pend[1];
                my = pend[2];
            end else begin
                merr = 1'b1;
            end
            pend.delete();
        end else if (pend[0] == 2) begin
            exp_q.push_back(((my * H + mx) << 8) | b);
            mx++;
            if (mx == H) begin
                mx = 0;
                my++;
                if (my == V) my = 0;
            end
            pend.delete();
        end else if (pend[0] == 3) begin
            for (int a = 0; a < N; a++) exp_q.push_back((a << 8) | b);
            fill_end = s + N;
            mx = 0;
            my = 0;
            pend.delete();
        end
    endfunction

    task automatic applyStimulus(input int b);
        @(negedge clk);
        bus.rx_data  = 8'(b);
        bus.rx_valid = 1'b1;
        modelByte(b, cyc);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic abortCs();
        bus.cs_n = 1'b1;
        repeat (5) @(negedge clk);
        pend.delete();
        bus.cs_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented write must be the oldest expected one; otherwise the port holds.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) busy_cycles++;
            if (bus.fb_we) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", longint'({bus.fb_addr, bus.fb_wdata}), -1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    checkOutput("write", longint'({bus.fb_addr, bus.fb_wdata}), e);
                    last_write = e;
                end
            end else begin
                checkOutput("hold", longint'({bus.fb_addr, bus.fb_wdata}), last_write);
            end
        end
    end

    initial begin
        longint bc0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.cs_n     = 1'b1;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_we",    bus.fb_we, 0);
        checkOutput("rst_busy",  bus.busy, 0);
        checkOutput("rst_err",   bus.err, 0);
        checkOutput("rst_addr",  bus.fb_addr, 0);
        checkOutput("rst_wdata", bus.fb_wdata, 0);
        rst_n    = 1'b1;
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] first write and cursor advance");
        applyStimulus(OP_WRITE_PIX);
        applyStimulus(8'hE0);
        checkOutput("first_write_latency", bus.fb_we, 1);
        applyStimulus(OP_WRITE_PIX);
        applyStimulus(8'h11);

        $display("[TB] last pixel and wrap");
        applyStimulus(OP_SET_POS); applyStimulus(8'h9F); applyStimulus(8'h77);
        applyStimulus(OP_WRITE_PIX); applyStimulus(8'h1C);
        applyStimulus(OP_WRITE_PIX); applyStimulus(8'h2D);

        $display("[TB] out-of-range position and clear");
        applyStimulus(OP_SET_POS); applyStimulus(8'hA0); applyStimulus(8'h05);
        checkOutput("err_x_range", bus.err, 1);
        applyStimulus(OP_WRITE_PIX); applyStimulus(8'h33);
        applyStimulus(OP_CLR_ERR);
        checkOutput("err_cleared", bus.err, 0);
        applyStimulus(OP_SET_POS); applyStimulus(8'h05); applyStimulus(8'h78);
        checkOutput("err_y_range", bus.err, merr);
        applyStimulus(8'hC3);
        checkOutput("err_bad_op", bus.err, merr);
        applyStimulus(OP_CLR_ERR);

        $display("[TB] chip-select abort");
        applyStimulus(OP_SET_POS); applyStimulus(8'h10);
        abortCs();
        applyStimulus(OP_WRITE_PIX); applyStimulus(8'hFF);

        $display("[TB] randomized commands");
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 10))
                0: applyStimulus(OP_NOP);
                1, 2: begin
                    applyStimulus(OP_SET_POS);
                    applyStimulus($urandom_range(0, 175));
                    applyStimulus($urandom_range(0, 135));
                end
                3: begin
                    applyStimulus(OP_SET_POS);
                    applyStimulus($urandom_range(157, 159));
                    applyStimulus($urandom_range(118, 119));
                end
                4, 5, 6: begin
                    applyStimulus(OP_WRITE_PIX);
                    applyStimulus($urandom_range(0, 255));
                end
                7: applyStimulus(OP_CLR_ERR);
                8: applyStimulus($urandom_range(5, 255));
                9: begin
                    applyStimulus(OP_SET_POS);
                    applyStimulus($urandom_range(0, 159));
                    abortCs();
                end
                default: begin
                    applyStimulus(OP_WRITE_PIX);
                    abortCs();
                end
            endcase
            checkOutput("err_rand", bus.err, merr);
        end

        $display("[TB] full-screen fill");
        applyStimulus(OP_CLR_ERR);
        applyStimulus(OP_FILL);
        bc0 = busy_cycles;
        applyStimulus(8'h03);
        checkOutput("busy_start", bus.busy, 1);
        repeat (100) @(negedge clk);
        applyStimulus(8'h55);
        checkOutput("err_midfill", bus.err, merr);
        for (int i = 0; i < N + 1000; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        checkOutput("fill_done", bus.busy, 0);
        checkOutput("busy_len", busy_cycles - bc0, N);
        applyStimulus(OP_WRITE_PIX); applyStimulus(8'h42);
        applyStimulus(OP_CLR_ERR);
        checkOutput("err_after_fill", bus.err, 0);

        $display("[TB] reset during fill");
        applyStimulus(OP_FILL);
        applyStimulus(8'hA5);
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midfill_rst_we",    bus.fb_we, 0);
        checkOutput("midfill_rst_busy",  bus.busy, 0);
        checkOutput("midfill_rst_addr",  bus.fb_addr, 0);
        checkOutput("midfill_rst_wdata", bus.fb_wdata, 0);
        checkOutput("midfill_rst_err",   bus.err, 0);
        exp_q.delete();
        pend.delete();
        mx = 0; my = 0; merr = 1'b0; fill_end = -1; last_write = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        applyStimulus(OP_WRITE_PIX); applyStimulus(8'h77);
        repeat (5) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Consumes the byte stream produced by the SPI slave receiver (rx_data/rx_valid) and interprets it as drawing commands from the Arduino master. Maintains a pixel cursor and drives the write port of the VGA framebuffer RAM. Sits between the SPI slave and the dual-port framebuffer whose read side is scanned by the VGA timing generator.

Parameters:
H_RES, 160, framebuffer width in pixels
V_RES, 120, framebuffer height in pixels
ADDR_W, 15, framebuffer address width (must satisfy 2^ADDR_W >= H_RES*V_RES)
PIX_W, 8, pixel data width (RRRGGGBB)

Ports:
clk  in  1  FPGA system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from SPI slave, valid only when rx_valid=1
rx_valid  in  1  single-cycle strobe, one per received byte
cs_n  in  1  raw SPI chip select (active low); synchronized internally
fb_we  out  1  framebuffer write enable
fb_addr  out  ADDR_W  framebuffer write address = y*H_RES + x
fb_wdata  out  PIX_W  framebuffer write data
busy  out  1  high while a FILL is running
err  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cursor x=0, y=0, cursor addr=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, err=0. Reset mid-FILL aborts immediately; no further writes.
- cs_n passes through a 2-flop synchronizer (reset value 1). A rising edge of synchronized cs_n in any state except FILL_RUN forces state to IDLE and discards a partially received command. The cursor is unchanged.
- Opcodes (first byte in IDLE): 0x00 NOP; 0x01 SET_POS (+x byte, +y byte); 0x02 WRITE_PIX (+color byte); 0x03 FILL (+color byte); 0x04 CLR_ERR. Any other opcode sets err and is otherwise ignored; the state stays IDLE.
- States and transitions:
  - IDLE: 0x01 goes to GET_X; 0x02 or 0x03 goes to GET_COLOR (opcode latched); 0x04 clears err.
  - GET_X: latch x byte, go to GET_Y.
  - GET_Y: if x<H_RES and y<V_RES, load cursor x, y and addr=y*H_RES+x (constant multiply, registered). Otherwise set err and leave the cursor unchanged. Go to IDLE.
  - GET_COLOR, WRITE_PIX case: the cycle after the color byte's rx_valid, fb_we=1 for exactly one cycle with fb_addr=cursor addr and fb_wdata=color. Then advance the cursor:
    - x+1 normally.
    - x=H_RES-1 wraps to x=0, y+1.
    - x=H_RES-1 and y=V_RES-1 wraps to x=0, y=0, addr=0.
    - addr tracks the cursor incrementally; no multiplier on this path.
    - Go to IDLE.
  - GET_COLOR, FILL case: go to FILL_RUN, busy=1.
  - FILL_RUN: one write per clock, fb_we=1, fb_addr counting 0 to H_RES*V_RES-1, fb_wdata=color. This takes exactly H_RES*V_RES cycles. Then fb_we=0, busy=0, state=IDLE, cursor reset to (0,0).
- rx_valid during FILL_RUN: byte dropped, err set. cs_n edges are ignored during FILL_RUN.
- rx_valid and a cs_n rising edge in the same cycle: the byte is processed first, then state is forced to IDLE (deassert wins).
- fb_we is never asserted outside a WRITE_PIX or FILL_RUN write. fb_addr and fb_wdata hold their last value when fb_we=0.
- err is cleared only by CLR_ERR or reset. If CLR_ERR arrives in the same cycle as a new error source, err stays set.

Decomposition:
- Package vga_cmd_pkg:
  - opcode constants OP_NOP, OP_SET_POS, OP_WRITE_PIX, OP_FILL, OP_CLR_ERR
  - state enum (IDLE, GET_X, GET_Y, GET_COLOR, FILL_RUN)
  - default H_RES/V_RES/PIX_W shared with the VGA timing and framebuffer blocks
- One sub-module: fb_cursor. It holds x, y and the linear addr, with load, increment-with-wrap and clear inputs.
- The FSM, cs_n synchronizer and error logic stay in the top.

Test Plan:
- Reset, then bytes 0x02, 0xE0 -> one fb_we pulse, fb_addr=0, fb_wdata=0xE0, one cycle after the second rx_valid. Cursor then at (1,0).
- 0x01,0x9F,0x77 then 0x02,0x1C -> write at addr 119*160+159=19199, data 0x1C. Cursor wraps to (0,0); next WRITE_PIX writes addr 0.
- 0x01,0xA0,0x05 (x=160 out of range) -> err=1, cursor unchanged, no write. Then 0x04 -> err=0.
- 0x03,0x03 -> busy=1 for exactly 19200 cycles with addr 0..19199 and data 0x03. A byte injected mid-fill is dropped and sets err.
- 0x01,0x10 then cs_n rises -> state IDLE. Next 0x02,0xFF writes at the previous cursor, not x=0x10.
- Assert rst_n=0 at fill cycle 500 -> fb_we=0 and all outputs at reset values immediately; no write after reset release without new commands.
